// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- small sequential ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per cycle) multiply, unsigned divide and remainder.
//
// Ports
//   clk     in   1      clock, all state changes on the rising edge
//   rst     in   1      synchronous active-high reset
//   start   in   1      request, only looked at while idle
//   ALUC    in   4      operation code, captured with start
//   A, B    in   WIDTH  operands, captured with start
//   busy    out  1      high while an iterative operation is running
//   done    out  1      one-cycle pulse when result/zero have just updated
//   result  out  WIDTH  registered result, held until the next done
//   zero    out  1      registered flag, updated together with result
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    // Iterative op kinds reuse the low two bits of the 10xx codes.
    localparam logic [1:0] KIND_MUL  = 2'b00;
    localparam logic [1:0] KIND_DIVU = 2'b01;
    localparam logic [1:0] KIND_REMU = 2'b10;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       kind_q, kind_d;
    // opA holds the multiplicand (shifting left) or the divisor (static).
    logic [WIDTH-1:0] opA_q, opA_d;
    // work holds the multiplier (shifting right) or dividend turning into quotient.
    logic [WIDTH-1:0] work_q, work_d;
    // acc holds the running product or the partial remainder.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] singleRes;
    logic             singleZero;
    logic [WIDTH-1:0] mulAcc;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remDiff;
    logic             remFits;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuot;
    logic [WIDTH-1:0] iterRes;

    // Combinational result of the single-cycle operations. The equality codes
    // drive zero with the compare flag itself rather than with result==0.
    always_comb begin
        singleRes  = '0;
        singleZero = 1'b0;
        case (ALUC)
            4'b0000: singleRes = A + B;
            4'b0001: singleRes = A - B;
            4'b0010: singleRes = A & B;
            4'b0011: singleRes = A | B;
            4'b0100: singleRes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0101: singleRes = {{(WIDTH-1){1'b0}}, (A != B)};
            4'b0110: singleRes = {{(WIDTH-1){1'b0}}, (A == B)};
            4'b0111: singleRes = {{(WIDTH-1){1'b0}}, (A < B)};
            default: singleRes = '0;
        endcase
        if (ALUC == 4'b0101 || ALUC == 4'b0110) begin
            singleZero = singleRes[0];
        end else begin
            singleZero = (singleRes == '0);
        end
    end

    // One iteration step for each iterative kind. The multiply is a plain
    // LSB-first shift-add; the divide is a restoring shift-subtract where the
    // borrow bit of the trial subtraction decides whether to keep it. A zero
    // divisor falls out naturally: every trial succeeds, giving an all-ones
    // quotient and the dividend as remainder.
    always_comb begin
        mulAcc   = acc_q + (work_q[0] ? opA_q : '0);
        remShift = {acc_q, work_q[WIDTH-1]};
        remDiff  = remShift - {1'b0, opA_q};
        remFits  = ~remDiff[WIDTH];
        divRem   = remFits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
        divQuot  = {work_q[WIDTH-2:0], remFits};
        case (kind_q)
            KIND_DIVU: iterRes = divQuot;
            KIND_REMU: iterRes = divRem;
            default:   iterRes = mulAcc;
        endcase
    end

    // Next-state logic. In IDLE a start either completes a single-cycle op at
    // once or captures the operands for the iterative engine. In ITER the
    // counter runs down from WIDTH and the final step publishes the result.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        kind_d   = kind_q;
        opA_d    = opA_q;
        work_d   = work_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUC == 4'b1000 || ALUC == 4'b1001 || ALUC == 4'b1010) begin
                        state_d = ITER;
                        count_d = CW'(WIDTH);
                        kind_d  = ALUC[1:0];
                        acc_d   = '0;
                        if (ALUC == 4'b1000) begin
                            opA_d  = A;
                            work_d = B;
                        end else begin
                            opA_d  = B;
                            work_d = A;
                        end
                    end else begin
                        result_d = singleRes;
                        zero_d   = singleZero;
                        done_d   = 1'b1;
                    end
                end
            end
            ITER: begin
                count_d = count_q - CW'(1);
                if (kind_q == KIND_MUL) begin
                    acc_d  = mulAcc;
                    opA_d  = opA_q << 1;
                    work_d = work_q >> 1;
                end else begin
                    acc_d  = divRem;
                    work_d = divQuot;
                end
                if (count_q == CW'(1)) begin
                    state_d  = IDLE;
                    result_d = iterRes;
                    zero_d   = (iterRes == '0);
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset takes priority over everything, so a start seen
    // together with reset is dropped and an operation in flight is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            kind_q   <= KIND_MUL;
            opA_q    <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            kind_q   <= kind_d;
            opA_q    <= opA_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ITER);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed self-checking bench for seq_alu at WIDTH=32.
// Expected results go into a scoreboard queue when an operation is started
// and are popped and compared when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
    } expect_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   ALUC;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;

    int compared;
    int mismatched;
    expect_t scoreboard[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALUC   (ALUC),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One counted comparison.
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive a one-cycle start and record what the DUT should eventually return.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expRes, input logic expZero);
        expect_t e;
        e.res  = expRes;
        e.zero = expZero;
        ALUC   = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        scoreboard.push_back(e);
        tick();
        start  = 1'b0;
    endtask

    // Wait (bounded) for done, counting edges since the start edge and busy
    // cycles. Operands are scrambled every cycle, and at pokeAt an extra
    // start is issued which must be ignored while busy.
    task automatic waitDone(input int budget, input int pokeAt, output int edges, output int busyCnt);
        edges   = 0;
        busyCnt = 0;
        while (done !== 1'b1 && edges < budget) begin
            if (busy === 1'b1) busyCnt++;
            ALUC  = 4'($urandom_range(0, 15));
            A     = $urandom;
            B     = $urandom;
            start = (edges == pokeAt) ? 1'b1 : 1'b0;
            if (edges == pokeAt) ALUC = 4'b0000;
            tick();
            edges++;
        end
        start = 1'b0;
    endtask

    // Wait for done, check timing, then pop the scoreboard and compare.
    task automatic checkOutput(input string tag, input int expLatency, input int expBusy, input int pokeAt);
        int edges;
        int busyCnt;
        expect_t e;
        waitDone(W + 8, pokeAt, edges, busyCnt);
        check({tag, ".done"}, 64'(done), 64'(1));
        check({tag, ".latency"}, 64'(edges), 64'(expLatency));
        check({tag, ".busyCycles"}, 64'(busyCnt), 64'(expBusy));
        check({tag, ".busyAfter"}, 64'(busy), 64'(0));
        if (scoreboard.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s.scoreboard: observed empty expected an entry", tag);
        end else begin
            e = scoreboard.pop_front();
            check({tag, ".result"}, 64'(result), 64'(e.res));
            check({tag, ".zero"}, 64'(zero), 64'(e.zero));
        end
    endtask

    // Directed sequence of operations.
    initial begin
        int dones;
        expect_t dropped;
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        ALUC  = 4'b0000;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.result", 64'(result), 64'(0));
        check("reset.zero", 64'(zero), 64'(0));
        rst = 1'b0;
        tick();

        // Single-cycle operations
        applyStimulus(4'b0000, 32'd7, -32'sd3, 32'd4, 1'b0);
        checkOutput("add", 0, 0, -1);
        applyStimulus(4'b0001, 32'd9, 32'd9, 32'd0, 1'b1);
        checkOutput("sub", 0, 0, -1);
        applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        checkOutput("slt", 0, 0, -1);
        applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        checkOutput("sltu", 0, 0, -1);
        applyStimulus(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        checkOutput("and", 0, 0, -1);
        applyStimulus(4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0);
        checkOutput("or", 0, 0, -1);
        applyStimulus(4'b1101, 32'd3, 32'd4, 32'd0, 1'b1);
        checkOutput("unused", 0, 0, -1);

        // Iterative operations; the mul also gets an ignored start at busy cycle 5
        applyStimulus(4'b1000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0);
        checkOutput("mul", W, W, 4);
        tick();
        check("mul.noExtraDone", 64'(done), 64'(0));
        applyStimulus(4'b1001, 32'd100, 32'd7, 32'd14, 1'b0);
        checkOutput("divu", W, W, -1);
        applyStimulus(4'b1010, 32'd100, 32'd7, 32'd2, 1'b0);
        checkOutput("remu", W, W, -1);
        applyStimulus(4'b1001, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        checkOutput("divu0", W, W, -1);
        applyStimulus(4'b1010, 32'd5, 32'd0, 32'd5, 1'b0);
        checkOutput("remu0", W, W, -1);

        // Reset at cycle 10 of a mul abandons it
        applyStimulus(4'b1000, 32'd3, 32'd3, 32'd9, 1'b0);
        dropped = scoreboard.pop_back();
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstMid.busy", 64'(busy), 64'(0));
        check("rstMid.done", 64'(done), 64'(0));
        check("rstMid.result", 64'(result), 64'(0));
        dones = 0;
        for (int i = 0; i < W + 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("rstMid.noDone", 64'(dones), 64'(0));
        applyStimulus(4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
        checkOutput("addAfterRst", 0, 0, -1);

        // Reset and start on the same edge: reset wins
        rst   = 1'b1;
        ALUC  = 4'b0000;
        A     = 32'd6;
        B     = 32'd6;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rstStart.done", 64'(done), 64'(0));
        check("rstStart.result", 64'(result), 64'(0));
        tick();
        check("rstStart.doneLater", 64'(done), 64'(0));

        // Equality codes, issued back to back in the done cycle
        applyStimulus(4'b0110, 32'd5, 32'd5, 32'd1, 1'b1);
        checkOutput("eq", 0, 0, -1);
        applyStimulus(4'b0101, 32'd5, 32'd5, 32'd0, 1'b0);
        checkOutput("neBackToBack", 0, 0, -1);
        tick();
        check("ne.donePulse", 64'(done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 8..64).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request; sampled only while idle (busy=0).
REQ-005 The block SHALL have port ALUC  input  4  operation select, sampled with start.
REQ-006 The block SHALL have ports A and B  input  WIDTH  signed operands, sampled with start.
REQ-007 The block SHALL have port busy  output  1  high while an iterative operation is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse when result/zero are updated.
REQ-009 The block SHALL have port result  output  WIDTH  registered result, held until the next done.
REQ-010 The block SHALL have port zero  output  1  registered flag, updated with result.

Function
REQ-011 The block SHALL support these ALUC codes: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 signed slt; 0101 not-equal; 0110 equal; 0111 unsigned sltu; 1000 mul; 1001 divu; 1010 remu.
REQ-012 The block SHALL use a two-state FSM, IDLE and ITER; reset enters IDLE.
REQ-013 In IDLE with start=1 and a single-cycle code (0000-0111, 1011-1111), the block SHALL register result/zero at that edge and assert done for exactly the following cycle; latency 1, busy stays 0.
REQ-014 Add/sub SHALL wrap modulo 2^WIDTH, with no overflow output.
REQ-015 slt SHALL compare two's-complement and sltu SHALL compare unsigned; result = 1 or 0, zero-extended.
REQ-016 For codes 0101/0110, the block SHALL set zero = (A!=B) / (A==B) respectively, with result = the same flag zero-extended.
REQ-017 For all other codes, the block SHALL set zero = (result == 0).
REQ-018 Codes 1011-1111 SHALL produce result 0, zero 1, done after 1 cycle.
REQ-019 In IDLE with start=1 and code 1000/1001/1010, the block SHALL latch the operands, load a cycle counter with WIDTH, enter ITER and drive busy=1 from the next cycle.
REQ-020 In ITER the block SHALL perform one shift-add (mul) or one restoring shift-subtract (divu/remu) step per cycle and decrement the counter.
REQ-021 On the edge where the counter goes 1->0, the block SHALL update result/zero, drive busy=0 and done=1, and return to IDLE; done rises exactly WIDTH cycles after the start edge.
REQ-022 mul SHALL return the low WIDTH bits of the unsigned product (identical to the signed low half).
REQ-023 divu SHALL return the unsigned quotient and remu the unsigned remainder.
REQ-024 On divide by zero, divu SHALL return all-ones and remu SHALL return A, each taking the full WIDTH cycles.
REQ-025 start while busy=1 SHALL be ignored, and A, B and ALUC changes during ITER SHALL NOT affect the result.
REQ-026 start SHALL be accepted in the cycle where done=1, since the FSM is then IDLE.
REQ-027 result and zero SHALL change only on a done edge or on reset.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, result=0, zero=0 and counter=0.
REQ-029 Reset mid-ITER SHALL abandon the operation; no done SHALL be produced for it.
REQ-030 If rst and start are both high at the same edge, rst SHALL win and start SHALL be discarded.

Verification (WIDTH=32)
REQ-031 The bench SHALL cover: add A=7, B=-3 -> next cycle done=1, result=4, zero=0; sub A=B=9 -> result 0, zero=1.
REQ-032 The bench SHALL cover: slt A=-1, B=1 -> result 1; sltu A=0xFFFFFFFF, B=1 -> result 0, zero=1.
REQ-033 The bench SHALL cover: mul 0x00010001*0x00010001 -> result 0x00020001; busy high exactly 32 cycles; done 32 cycles after start; a start issued at busy cycle 5 is ignored.
REQ-034 The bench SHALL cover: divu 100/7 -> 14; remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
REQ-035 The bench SHALL cover: rst at cycle 10 of a mul -> busy=0, result=0, no done pulse; a following add 1+1 -> result 2 after 1 cycle.
REQ-036 The bench SHALL cover: A=B=5 with ALUC 0110 -> zero=1, result=1; with ALUC 0101 -> zero=0, result=0; a back-to-back start in the done cycle is accepted.
